// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding,
// BCD digit limits and small helpers.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam logic [7:0] CS_LIMIT    = 8'h99;
  localparam logic [7:0] SEC_LIMIT   = 8'h59;
  localparam int         MAX_MIN_DEF = 59;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cs;
  } sw_time_t;

  function automatic logic [7:0] to_bcd8(input int v);
    to_bcd8 = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd2_counter.sv
// Two-digit BCD counter with synchronous clear and wrap at LIMIT; co pulses
// on the enabled increment that wraps.
module bcd2_counter #(
  parameter logic [7:0] LIMIT = 8'h99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] q,
  output logic       co
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 8'h00;
    end else if (en) begin
      if (q_q == LIMIT)           q_d = 8'h00;
      else if (q_q[3:0] == 4'd9)  q_d = {q_q[7:4] + 4'd1, 4'd0};
      else                        q_d = {q_q[7:4], q_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 8'h00;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign co = en && (q_q == LIMIT);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM over a cs/sec/min BCD
// cascade, with a lap snapshot that freezes the display while in LAP.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int MAX_MIN = MAX_MIN_DEF
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       run_out,
  output logic [1:0] state_out,
  output logic [7:0] disp_cs,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic       overflow
);

  localparam logic [7:0] MIN_LIMIT = to_bcd8(MAX_MIN);

  sw_state_e state_q, state_d;
  logic      run_q, run_d;
  logic      ovf_q, ovf_d;
  sw_time_t  snap_q, snap_d;
  sw_time_t  live, disp;
  logic      clr_cnt, cnt_en, cs_co, sec_co, min_co;

  // Ticks are judged against the pre-edge state, so a stop press still counts.
  assign cnt_en = tick_in && (state_q == ST_RUN || state_q == ST_LAP);

  bcd2_counter #(.LIMIT(CS_LIMIT)) u_cs (
    .clk(clock_in), .rst(reset), .clr(clr_cnt), .en(cnt_en), .q(live.cs),  .co(cs_co));
  bcd2_counter #(.LIMIT(SEC_LIMIT)) u_sec (
    .clk(clock_in), .rst(reset), .clr(clr_cnt), .en(cs_co),  .q(live.sec), .co(sec_co));
  bcd2_counter #(.LIMIT(MIN_LIMIT)) u_min (
    .clk(clock_in), .rst(reset), .clr(clr_cnt), .en(sec_co), .q(live.min), .co(min_co));

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ovf_q   <= ovf_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_clear)      clr_cnt = 1'b1;
        else if (btn_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (btn_start)      state_d = ST_PAUSE;
        else if (btn_lap)   state_d = ST_LAP;
      end
      ST_LAP: begin
        if (btn_start)      state_d = ST_PAUSE;
        else if (btn_lap)   state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (btn_clear) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
        end else if (btn_start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
    ovf_d  = clr_cnt ? 1'b0 : (ovf_q | min_co);
    snap_d = (state_q == ST_RUN && state_d == ST_LAP) ? live : snap_q;
    disp   = (state_q == ST_LAP) ? snap_q : live;
  end

  assign run_out   = run_q;
  assign state_out = state_q;
  assign overflow  = ovf_q;
  assign disp_cs   = disp.cs;
  assign disp_sec  = disp.sec;
  assign disp_min  = disp.min;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a random
// run compared against a centisecond-integer reference model.
module tb_stopwatch_ctrl;

  localparam int MM   = 1;
  localparam int WRAP = (MM + 1) * 6000;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1, tick_in = 1'b0;
  logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
  logic       run_out, overflow;
  logic [1:0] state_out;
  logic [7:0] disp_cs, disp_sec, disp_min;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: elapsed time as plain centiseconds
  int m_t = 0, m_st = 0, m_snap = 0;
  bit m_ovf = 1'b0;

  stopwatch_ctrl #(.MAX_MIN(MM)) dut (
    .clock_in(clock_in), .reset(reset), .tick_in(tick_in),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .run_out(run_out), .state_out(state_out),
    .disp_cs(disp_cs), .disp_sec(disp_sec), .disp_min(disp_min),
    .overflow(overflow));

  always #5 clock_in = ~clock_in;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [23:0] exp_disp();
    int shown;
    shown = (m_st == 3) ? m_snap : m_t;
    return {bcd(shown / 6000), bcd((shown / 100) % 60), bcd(shown % 100)};
  endfunction

  // one clock with the given inputs; model advances on the same edge
  task automatic cyc(input logic r, input logic tk, input logic s,
                     input logic l, input logic c);
    int old_t;
    reset = r; tick_in = tk; btn_start = s; btn_lap = l; btn_clear = c;
    @(posedge clock_in);
    if (r) begin
      m_t = 0; m_st = 0; m_snap = 0; m_ovf = 1'b0;
    end else begin
      old_t = m_t;
      if (tk && (m_st == 1 || m_st == 3)) begin
        m_t = m_t + 1;
        if (m_t == WRAP) begin m_t = 0; m_ovf = 1'b1; end
      end
      if (c && (m_st == 0 || m_st == 2)) begin
        m_st = 0; m_t = 0; m_ovf = 1'b0;
      end else if (s) begin
        m_st = (m_st == 0 || m_st == 2) ? 1 : 2;
      end else if (l) begin
        if (m_st == 1) begin m_st = 3; m_snap = old_t; end
        else if (m_st == 3) m_st = 1;
      end
    end
    @(negedge clock_in);
    reset = 1'b0; tick_in = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 1);
    n_cmp++;
    if ({state_out, run_out, overflow, disp_min, disp_sec, disp_cs} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_state: got st=%0d run=%0b ovf=%0b disp=%h, want all zero",
               state_out, run_out, overflow, {disp_min, disp_sec, disp_cs});
    end
    cyc(0, 1, 0, 0, 0);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h0) begin
      n_bad++;
      $display("FAIL idle_tick_ignored: got %h want 000000", {disp_min, disp_sec, disp_cs});
    end
  endtask

  task automatic test_run_150();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(150);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000150 || state_out !== 2'd1 || run_out !== 1'b1) begin
      n_bad++;
      $display("FAIL run_150: got disp=%h st=%0d run=%0b want 000150 st=1 run=1",
               {disp_min, disp_sec, disp_cs}, state_out, run_out);
    end
  endtask

  task automatic test_lap();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(10);
    cyc(0, 0, 0, 1, 0);
    ticks(20);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000010 || state_out !== 2'd3) begin
      n_bad++;
      $display("FAIL lap_hold: got disp=%h st=%0d want 000010 st=3",
               {disp_min, disp_sec, disp_cs}, state_out);
    end
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000030 || state_out !== 2'd1) begin
      n_bad++;
      $display("FAIL lap_release: got disp=%h st=%0d want 000030 st=1",
               {disp_min, disp_sec, disp_cs}, state_out);
    end
  endtask

  task automatic test_overflow();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(WRAP - 1);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h015999 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL preload_max: got disp=%h ovf=%0b want 015999 ovf=0",
               {disp_min, disp_sec, disp_cs}, overflow);
    end
    ticks(1);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000000 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap: got disp=%h ovf=%0b want 000000 ovf=1",
               {disp_min, disp_sec, disp_cs}, overflow);
    end
    ticks(3);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000003 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: got disp=%h ovf=%0b want 000003 ovf=1",
               {disp_min, disp_sec, disp_cs}, overflow);
    end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    n_cmp++;
    if (overflow !== 1'b0 || state_out !== 2'd0 || {disp_min, disp_sec, disp_cs} !== 24'h0) begin
      n_bad++;
      $display("FAIL clear_ovf: got ovf=%0b st=%0d disp=%h want 0 0 000000",
               overflow, state_out, {disp_min, disp_sec, disp_cs});
    end
  endtask

  task automatic test_start_tick();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(5);
    cyc(0, 1, 1, 0, 0);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000006 || state_out !== 2'd2 || run_out !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_with_tick: got disp=%h st=%0d run=%0b want 000006 st=2 run=0",
               {disp_min, disp_sec, disp_cs}, state_out, run_out);
    end
    ticks(3);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000006) begin
      n_bad++;
      $display("FAIL pause_hold: got %h want 000006", {disp_min, disp_sec, disp_cs});
    end
  endtask

  task automatic test_pause_clear();
    cyc(0, 1, 1, 0, 1);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h0 || state_out !== 2'd0) begin
      n_bad++;
      $display("FAIL clear_beats_start: got disp=%h st=%0d want 000000 st=0",
               {disp_min, disp_sec, disp_cs}, state_out);
    end
    cyc(0, 0, 1, 0, 0);
    ticks(7);
    cyc(0, 0, 0, 0, 1);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000007 || state_out !== 2'd1) begin
      n_bad++;
      $display("FAIL clear_in_run: got disp=%h st=%0d want 000007 st=1",
               {disp_min, disp_sec, disp_cs}, state_out);
    end
  endtask

  task automatic test_reset_in_lap();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(500);
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if ({disp_min, disp_sec, disp_cs} !== 24'h000500 || state_out !== 2'd3) begin
      n_bad++;
      $display("FAIL lap_at_5s: got disp=%h st=%0d want 000500 st=3",
               {disp_min, disp_sec, disp_cs}, state_out);
    end
    cyc(1, 1, 0, 0, 0);
    n_cmp++;
    if ({state_out, run_out, overflow, disp_min, disp_sec, disp_cs} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_in_lap: got st=%0d run=%0b ovf=%0b disp=%h want all zero",
               state_out, run_out, overflow, {disp_min, disp_sec, disp_cs});
    end
  endtask

  task automatic test_random();
    int b;
    logic s, l, c;
    for (int i = 0; i < 3000; i++) begin
      b = $urandom_range(0, 15);
      s = (b == 0 || b == 3);
      l = (b == 1 || b == 3);
      c = (b == 2);
      cyc(($urandom_range(0, 299) == 0), $urandom_range(0, 1), s, l, c);
      n_cmp++;
      if ({disp_min, disp_sec, disp_cs} !== exp_disp() || state_out !== 2'(m_st) ||
          run_out !== (m_st == 1 || m_st == 3) || overflow !== m_ovf) begin
        n_bad++;
        $display("FAIL random[%0d]: got disp=%h st=%0d run=%0b ovf=%0b want disp=%h st=%0d run=%0b ovf=%0b",
                 i, {disp_min, disp_sec, disp_cs}, state_out, run_out, overflow,
                 exp_disp(), m_st, (m_st == 1 || m_st == 3), m_ovf);
      end
    end
  endtask

  initial begin
    @(negedge clock_in);
    test_reset();
    test_run_150();
    test_lap();
    test_overflow();
    test_start_tick();
    test_pause_clear();
    test_reset_in_lap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: MAX_MIN, default 59, highest minute value before wrap (BCD range 1..99).
REQ-002 Port: clock_in  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: tick_in  input  1  one-cycle 0.01 s enable pulse from the divider chain.
REQ-005 Port: btn_start  input  1  one-cycle pulse; start/stop toggle.
REQ-006 Port: btn_lap  input  1  one-cycle pulse; lap freeze / lap release.
REQ-007 Port: btn_clear  input  1  one-cycle pulse; clear count.
REQ-008 Port: run_out  output  1  high while the count advances (RUN or LAP).
REQ-009 Port: state_out  output  2  current FSM state encoding.
REQ-010 Port: disp_cs  output  8  two BCD digits, centiseconds 00..99.
REQ-011 Port: disp_sec  output  8  two BCD digits, seconds 00..59.
REQ-012 Port: disp_min  output  8  two BCD digits, minutes 00..MAX_MIN.
REQ-013 Port: overflow  output  1  sticky; set on wrap past MAX_MIN:59.99.

Function
REQ-014 FSM states SHALL be IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-015 IDLE: btn_start -> RUN; btn_lap ignored.
REQ-016 RUN: btn_start -> PAUSE; btn_lap -> LAP.
REQ-017 LAP: btn_lap -> RUN (display resumes live); btn_start -> PAUSE (display shows live count).
REQ-018 PAUSE: btn_start -> RUN; btn_lap ignored.
REQ-019 btn_clear in IDLE or PAUSE -> IDLE, count and overflow zeroed the same edge; ignored in RUN and LAP.
REQ-020 Simultaneous buttons: priority btn_clear > btn_start > btn_lap; lower-priority pulses that cycle are discarded.
REQ-021 Count SHALL advance on tick_in only when the pre-edge state is RUN or LAP; a tick coinciding with a start/stop press is evaluated against the pre-edge state.
REQ-022 Count SHALL be BCD: cs units 9->0 carries to tens; cs 99->00 carries to seconds; sec 59->00 carries to minutes; min MAX_MIN->00 sets overflow.
REQ-023 Count register update latency: one clock after tick_in is sampled.
REQ-024 In IDLE, RUN and PAUSE, disp_* SHALL equal the count registers directly (no extra delay).
REQ-025 On entering LAP, disp_* SHALL hold the count value present at the transition edge (pre-increment if tick_in coincides); held until LAP is left.
REQ-026 overflow SHALL remain set until clear or reset; counting continues after wrap.
REQ-027 run_out SHALL be a registered decode of state (1 in RUN/LAP).
REQ-028 tick_in and buttons assumed synchronous, single-cycle; a button held high SHALL act as one press per cycle high (no internal edge detect).

Reset
REQ-029 reset SHALL take priority over all inputs.
REQ-030 Reset values: state IDLE, state_out 0, run_out 0, disp_cs/disp_sec/disp_min 8'h00, lap snapshot 0, overflow 0.
REQ-031 Reset asserted mid-count SHALL zero everything at the next edge; first tick after reset release in IDLE is not counted.

Structure
REQ-032 Shared package SHALL hold: state encoding constants, BCD limit constants (cs 99, sec 59), default MAX_MIN.
REQ-033 One sub-module bcd2_counter SHALL implement a two-digit BCD counter with enable, clear, parameterised limit and carry-out; instantiated three times in a cascade.
REQ-034 Top level SHALL contain only the FSM, lap snapshot register and output muxing.

Verification
REQ-035 Reset, btn_start, 150 tick_in pulses -> disp 00:01.50, state_out 1, run_out 1.
REQ-036 From RUN at 00:00.10, btn_lap, 20 ticks -> disp holds 00:00.10; btn_lap -> disp 00:00.30.
REQ-037 Preload 59:59.99 via ticks (MAX_MIN=59), one tick -> disp 00:00.00, overflow 1; btn_start, btn_clear -> overflow 0, state IDLE.
REQ-038 RUN, btn_start and tick_in same cycle -> tick counted, state PAUSE; further ticks ignored.
REQ-039 PAUSE, btn_clear and btn_start same cycle -> IDLE, count 0; btn_clear in RUN -> no effect.
REQ-040 Reset asserted in LAP at 00:05.00 -> all outputs zero next edge, state IDLE.
